// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between spi_slave and user logic: decodes 32-bit frames, updates registers, queues 24-bit replies.
// Optional build macro SPI_CMD_STATS_EN adds a frame counter and the 0x06 read-count opcode.
module spi_cmd_ctrl #(
   parameter int LED_W        = 16,
   parameter int RESP_TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_data_available,
   input  logic [31:0]      rd_data,
   output logic             rd_ack,
   input  logic             wr_buffer_free,
   output logic             wr_en,
   output logic [23:0]      wr_data,
   output logic [LED_W-1:0] leds,
   output logic [15:0]      inv_reg,
   output logic             link_up,
   output logic             resp_dropped,
   output logic [2:0]       fsm_state
);

   localparam int TW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LATCH     = 3'd1,
      ACK_WAIT  = 3'd2,
      RESP_WAIT = 3'd3,
      RESP      = 3'd4
   } state_t;

   state_t          state;
   logic [7:0]      op;
   logic [15:0]     payload;
   logic            pending;
   logic [23:0]     reply;
   logic [TW-1:0]   tmo;
   logic [15:0]     leds_ext;
   logic            cmd_reply;
   logic [15:0]     cmd_value;
   logic            unused_bits;

`ifdef SPI_CMD_STATS_EN
   logic [15:0]     frame_cnt;
   logic [15:0]     frame_next;
   // The 0x06 reply already counts the frame that asked for it.
   assign frame_next = frame_cnt + 16'd1;
`endif

   assign fsm_state   = state;
   assign unused_bits = ^rd_data[31:24];

   always_comb begin
      leds_ext = '0;
      leds_ext[LED_W-1:0] = leds;
   end

   // Reply decode; every replying opcode is gated by link_up.
   always_comb begin
      cmd_reply = 1'b0;
      cmd_value = '0;
      case (op)
         8'h02: begin cmd_reply = link_up; cmd_value = ~payload; end
         8'h03: begin cmd_reply = link_up; cmd_value = inv_reg;  end
         8'h04: begin cmd_reply = link_up; cmd_value = payload;  end
         8'h05: begin cmd_reply = link_up; cmd_value = leds_ext; end
`ifdef SPI_CMD_STATS_EN
         8'h06: begin cmd_reply = link_up; cmd_value = frame_next; end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         rd_ack       <= 1'b0;
         wr_en        <= 1'b0;
         wr_data      <= '0;
         leds         <= '0;
         inv_reg      <= '0;
         link_up      <= 1'b0;
         resp_dropped <= 1'b0;
         op           <= '0;
         payload      <= '0;
         pending      <= 1'b0;
         reply        <= '0;
         tmo          <= '0;
`ifdef SPI_CMD_STATS_EN
         frame_cnt    <= '0;
`endif
      end else begin
         rd_ack <= 1'b0;
         wr_en  <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_data_available) begin
                  op      <= rd_data[7:0];
                  payload <= rd_data[23:8];
                  state   <= LATCH;
               end
            end
            LATCH: begin
               rd_ack  <= 1'b1;
               pending <= cmd_reply;
               reply   <= {op, cmd_value};
`ifdef SPI_CMD_STATS_EN
               frame_cnt <= frame_next;
`endif
               if (op == 8'h01) begin
                  link_up      <= 1'b1;
                  resp_dropped <= 1'b0;
               end
               if (link_up && op == 8'h02) inv_reg <= ~payload;
               if (link_up && op == 8'h04) leds    <= payload[LED_W-1:0];
               state <= ACK_WAIT;
            end
            // spi_slave holds the flag until its bit counter idles; waiting here avoids a double decode.
            ACK_WAIT: begin
               if (!rd_data_available) begin
                  tmo   <= TW'(RESP_TIMEOUT);
                  state <= pending ? RESP_WAIT : IDLE;
               end
            end
            RESP_WAIT: begin
               if (wr_buffer_free) begin
                  wr_en   <= 1'b1;
                  wr_data <= reply;
                  state   <= RESP;
               end else if (tmo == '0) begin
                  resp_dropped <= 1'b1;
                  state        <= IDLE;
               end else begin
                  tmo <= tmo - 1'b1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: transaction-level model, per-cycle compare process, directed plus random frames.
module tb_spi_cmd_ctrl;

   localparam int LED_W = 16;
   localparam int TMO   = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             rd_data_available;
   logic [31:0]      rd_data;
   logic             rd_ack;
   logic             wr_buffer_free;
   logic             wr_en;
   logic [23:0]      wr_data;
   logic [LED_W-1:0] leds;
   logic [15:0]      inv_reg;
   logic             link_up;
   logic             resp_dropped;
   logic [2:0]       fsm_state;

   spi_cmd_ctrl #(.LED_W(LED_W), .RESP_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .rd_data_available(rd_data_available), .rd_data(rd_data), .rd_ack(rd_ack),
      .wr_buffer_free(wr_buffer_free), .wr_en(wr_en), .wr_data(wr_data),
      .leds(leds), .inv_reg(inv_reg), .link_up(link_up), .resp_dropped(resp_dropped),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int acks     = 0;
   int n_wr     = 0;

   // behavioural model state
   logic [15:0] m_leds, m_inv, m_frames;
   logic        m_link, m_dropped;
   logic [23:0] m_wr_data;
   logic [23:0] exp_q[$];
   logic [7:0]  cur_op;
   logic [15:0] cur_pay;
   bit          plan_deliver;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_leds = '0; m_inv = '0; m_frames = '0; m_link = 1'b0; m_dropped = 1'b0;
      m_wr_data = '0;
      exp_q.delete();
   endfunction

   // Applies one acknowledged frame by the opcode rules.
   function automatic void model_apply(input logic [7:0] op, input logic [15:0] pay);
      bit          has;
      logic [15:0] val;
      logic [16:0] mask;
      has = 1'b0;
      val = '0;
      mask = (17'd1 << LED_W) - 17'd1;
      m_frames = m_frames + 16'd1;
      case (op)
         8'h01: begin m_link = 1'b1; m_dropped = 1'b0; end
         8'h02: if (m_link) begin m_inv = ~pay; has = 1'b1; val = m_inv; end
         8'h03: if (m_link) begin has = 1'b1; val = m_inv; end
         8'h04: if (m_link) begin m_leds = pay & mask[15:0]; has = 1'b1; val = pay; end
         8'h05: if (m_link) begin has = 1'b1; val = m_leds; end
`ifdef SPI_CMD_STATS_EN
         8'h06: if (m_link) begin has = 1'b1; val = m_frames; end
`endif
         default: ;
      endcase
      if (has) begin
         if (plan_deliver) exp_q.push_back({op, val});
         else m_dropped = 1'b1;
      end
   endfunction

   // Compare process
   always @(negedge clk) begin
      if (!reset) begin
         if (rd_ack) begin
            acks++;
            model_apply(cur_op, cur_pay);
         end
         if (wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               check("unexpected_wr_en", 32'(wr_en), 32'd0);
            end else begin
               m_wr_data = exp_q.pop_front();
            end
         end
         check("wr_data", 32'(wr_data), 32'(m_wr_data));
         check("leds", 32'(leds), 32'(m_leds));
         check("inv_reg", 32'(inv_reg), 32'(m_inv));
         check("link_up", 32'(link_up), 32'(m_link));
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      rd_data_available = 1'b0;
      wr_buffer_free = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // One frame: raise flag, wait for ack, hold, drop, release wr_buffer_free after dly cycles (or never).
   task automatic send(input logic [7:0] op, input logic [15:0] pay, input bit deliver,
                       input int hold, input int dly);
      int         cyc;
      logic [7:0] junk;
      junk = 8'($urandom_range(0, 255));
      acks = 0;
      cur_op = op;
      cur_pay = pay;
      plan_deliver = deliver;
      wr_buffer_free = 1'b0;
      rd_data = {junk, pay, op};
      rd_data_available = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!rd_ack && cyc < 10);
      check("ack_latency", 32'(cyc), 32'd2);
      repeat (hold) @(posedge clk);
      #1 rd_data_available = 1'b0;
      rd_data = $urandom();
      if (deliver) begin
         repeat (dly) @(posedge clk);
         #1 wr_buffer_free = 1'b1;
         repeat (20) @(posedge clk);
      end else begin
         repeat (20) @(posedge clk);
         #1 wr_buffer_free = 1'b1;
         @(posedge clk);
      end
      #1;
      check("ack_count", 32'(acks), 32'd1);
      check("reply_outstanding", 32'(exp_q.size()), 32'd0);
      check("resp_dropped", 32'(resp_dropped), 32'(m_dropped));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr_before;
      reset = 1'b1;
      rd_data_available = 1'b0;
      rd_data = '0;
      wr_buffer_free = 1'b1;
      plan_deliver = 1'b1;
      cur_op = '0;
      cur_pay = '0;
      model_reset();
      do_reset();
      check("rst_rd_ack", 32'(rd_ack), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_leds", 32'(leds), 32'd0);
      check("rst_inv_reg", 32'(inv_reg), 32'd0);
      check("rst_link_up", 32'(link_up), 32'd0);
      check("rst_resp_dropped", 32'(resp_dropped), 32'd0);
      check("rst_state", 32'(fsm_state), 32'd0);

      // before INIT: ignored, no reply
      wr_before = n_wr;
      send(8'h02, 16'h1234, 1'b1, 0, 0);
      check("pre_init_inv", 32'(inv_reg), 32'h0);
      check("pre_init_no_wr", 32'(n_wr - wr_before), 32'd0);
      send(8'h01, 16'h0000, 1'b1, 0, 0);
      check("init_link", 32'(link_up), 32'd1);

      send(8'h02, 16'h1234, 1'b1, 1, 0);
      check("wr_inv_reg", 32'(inv_reg), 32'hEDCB);
      check("wr_inv_reply", 32'(wr_data), 32'h02EDCB);
      send(8'h03, 16'hFFFF, 1'b1, 0, 3);
      check("rd_inv_reply", 32'(wr_data), 32'h03EDCB);
      send(8'h04, 16'hA5C3, 1'b1, 2, 1);
      check("wr_leds", 32'(leds), 32'hA5C3);
      check("wr_leds_reply", 32'(wr_data), 32'h04A5C3);
      send(8'h05, 16'h0000, 1'b1, 0, 5);
      check("rd_leds_reply", 32'(wr_data), 32'h05A5C3);

      // timeout: buffer never free
      wr_before = n_wr;
      send(8'h03, 16'h0000, 1'b0, 0, 0);
      check("drop_flag", 32'(resp_dropped), 32'd1);
      check("drop_no_wr", 32'(n_wr - wr_before), 32'd0);
      send(8'h05, 16'h0000, 1'b1, 0, 0);
      check("after_drop_reply", 32'(wr_data), 32'h05A5C3);
      send(8'h01, 16'h0000, 1'b1, 0, 0);
      check("init_clears_drop", 32'(resp_dropped), 32'd0);

      // flag held high for 50 cycles
      wr_before = n_wr;
      send(8'h05, 16'h0000, 1'b1, 50, 2);
      check("long_hold_one_wr", 32'(n_wr - wr_before), 32'd1);

      // frame counter opcode
      do_reset();
      send(8'h01, 16'h0000, 1'b1, 0, 0);
      for (int i = 0; i < 3; i++) send(8'h00, 16'($urandom()), 1'b1, 0, 0);
      send(8'h06, 16'h0000, 1'b1, 0, 0);
`ifdef SPI_CMD_STATS_EN
      check("stats_reply", 32'(wr_data), 32'h060005);
`else
      check("no_stats_reply", 32'(wr_data), 32'h0);
`endif

      // reset while waiting for buffer space
      wr_before = n_wr;
      acks = 0;
      cur_op = 8'h03; cur_pay = 16'h0; plan_deliver = 1'b0;
      wr_buffer_free = 1'b0;
      rd_data = {8'h00, 16'h0000, 8'h03};
      rd_data_available = 1'b1;
      repeat (3) @(posedge clk);
      #1 rd_data_available = 1'b0;
      repeat (4) @(posedge clk);
      #1 check("pre_reset_in_resp_wait", 32'(fsm_state), 32'd3);
      do_reset();
      repeat (20) @(posedge clk);
      #1;
      check("reset_mid_no_wr", 32'(n_wr - wr_before), 32'd0);
      check("reset_mid_link", 32'(link_up), 32'd0);
      check("reset_mid_drop", 32'(resp_dropped), 32'd0);
      check("reset_mid_wr_data", 32'(wr_data), 32'd0);
      check("reset_mid_state", 32'(fsm_state), 32'd0);

      // frame present during reset is not acked
      acks = 0;
      reset = 1'b1;
      rd_data = {8'h00, 16'h5555, 8'h01};
      rd_data_available = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      rd_data_available = 1'b0;
      repeat (5) @(posedge clk);
      #1 check("reset_frame_not_acked", 32'(acks), 32'd0);
      check("reset_frame_no_link", 32'(link_up), 32'd0);

      // random frames
      for (int i = 0; i < 300; i++) begin
         int         r;
         logic [7:0] op;
         if (i == 150) do_reset();
         r = $urandom_range(0, 9);
         if (r < 7) op = 8'(r);
         else if (r == 7) op = 8'h01;
         else op = 8'($urandom_range(7, 255));
         send(op, 16'($urandom()), ($urandom_range(0, 4) != 0), $urandom_range(0, 3),
              $urandom_range(0, 6));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
